// File: rtl/afe_spi_shifter.sv
// AFE attenuator/switch SPI loader: shifts one word MSB first to the
// selected AFE bus, then pulses that bus's latch enable.
module afe_spi_shifter #(
    parameter int CLK_RATE      = 99999001,
    parameter int SPI_RATE      = 5000000,
    parameter int DATA_WIDTH    = 16,
    parameter int CHANNEL_COUNT = 2,
    parameter int CH_SEL_WIDTH  =
        (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
    input  logic                     sysClk,
    input  logic                     sysReset,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [CH_SEL_WIDTH-1:0]  cmdChannel,
    input  logic [DATA_WIDTH-1:0]    cmdData,
    output logic                     busy,
    output logic                     errorStrobe,
    output logic [15:0]              doneCount,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_CLK,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_SDI,
    output logic [CHANNEL_COUNT-1:0] AFE_SPI_LE
);

    localparam int HALF_PERIOD =
        (CLK_RATE + 2 * SPI_RATE - 1) / (2 * SPI_RATE);
    localparam int CNT_W =
        (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD + 1) : 1;
    localparam int BIT_W =
        (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        LATCH,
        GAP
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         hp_cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0]    data_r;
    logic [CHANNEL_COUNT-1:0] ch_mask;
    logic [CHANNEL_COUNT-1:0] spi_clk;
    logic [CHANNEL_COUNT-1:0] spi_sdi;
    logic [CHANNEL_COUNT-1:0] spi_le;
    logic                     ready_r;
    logic                     busy_r;
    logic                     err_r;
    logic [15:0]              done_cnt;

    logic [CHANNEL_COUNT-1:0] sel_mask;
    logic                     sel_ok;
    logic                     accept;

    // An out-of-range channel decodes to an empty mask, so the
    // transfer still runs its full length with every pin held at 0.
    always_comb begin
        sel_mask = '0;
        sel_ok   = 1'b0;
        for (int i = 0; i < CHANNEL_COUNT; i++) begin
            if (cmdChannel == CH_SEL_WIDTH'(i)) begin
                sel_mask[i] = 1'b1;
                sel_ok      = 1'b1;
            end
        end
    end

    assign accept = cmdValid && ready_r;

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            state    <= IDLE;
            hp_cnt   <= '0;
            bit_cnt  <= '0;
            data_r   <= '0;
            ch_mask  <= '0;
            spi_clk  <= '0;
            spi_sdi  <= '0;
            spi_le   <= '0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            err_r    <= 1'b0;
            done_cnt <= '0;
        end else begin
            err_r <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    data_r  <= cmdData;
                    ch_mask <= sel_mask;
                    err_r   <= ~sel_ok;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                    hp_cnt  <= HP_LAST;
                    bit_cnt <= BIT_LAST;
                    spi_sdi <= sel_mask &
                        {CHANNEL_COUNT{cmdData[DATA_WIDTH-1]}};
                    state   <= SETUP;
                end
            end else if (hp_cnt != '0) begin
                hp_cnt <= hp_cnt - 1'b1;
            end else begin
                hp_cnt <= HP_LAST;
                unique case (state)
                    SETUP: begin
                        spi_clk <= ch_mask;
                        state   <= HIGH;
                    end
                    HIGH: begin
                        spi_clk <= '0;
                        if (bit_cnt == '0) begin
                            spi_sdi <= '0;
                        end else begin
                            spi_sdi <= ch_mask &
                                {CHANNEL_COUNT{data_r[bit_cnt - 1'b1]}};
                        end
                        state <= LOW;
                    end
                    LOW: begin
                        if (bit_cnt == '0) begin
                            spi_le <= ch_mask;
                            state  <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            spi_clk <= ch_mask;
                            state   <= HIGH;
                        end
                    end
                    LATCH: begin
                        spi_le <= '0;
                        state  <= GAP;
                    end
                    GAP: begin
                        ready_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        done_cnt <= done_cnt + 16'd1;
                        state    <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cmdReady    = ready_r;
    assign busy        = busy_r;
    assign errorStrobe = err_r;
    assign doneCount   = done_cnt;
    assign AFE_SPI_CLK = spi_clk;
    assign AFE_SPI_SDI = spi_sdi;
    assign AFE_SPI_LE  = spi_le;

endmodule

// File: tb/tb_afe_spi_shifter.sv
// Scoreboard bench for afe_spi_shifter: random and directed commands,
// a monitor reassembles each transfer from the pins and compares.
module tb_afe_spi_shifter;

    localparam int W    = 16;
    localparam int C    = 3;
    localparam int H    = 10;
    localparam int BUSY = H * (2 * W + 3);
    localparam int LIM  = 4 * BUSY;

    logic         sysClk = 1'b0;
    logic         sysReset = 1'b1;
    logic         cmdValid = 1'b0;
    logic [1:0]   cmdChannel = '0;
    logic [W-1:0] cmdData = '0;
    logic         cmdReady;
    logic         busy;
    logic         errorStrobe;
    logic [15:0]  doneCount;
    logic [C-1:0] AFE_SPI_CLK;
    logic [C-1:0] AFE_SPI_SDI;
    logic [C-1:0] AFE_SPI_LE;

    always #5 sysClk = ~sysClk;

    afe_spi_shifter #(
        .CHANNEL_COUNT(C)
    ) dut (
        .sysClk(sysClk),
        .sysReset(sysReset),
        .cmdValid(cmdValid),
        .cmdReady(cmdReady),
        .cmdChannel(cmdChannel),
        .cmdData(cmdData),
        .busy(busy),
        .errorStrobe(errorStrobe),
        .doneCount(doneCount),
        .AFE_SPI_CLK(AFE_SPI_CLK),
        .AFE_SPI_SDI(AFE_SPI_SDI),
        .AFE_SPI_LE(AFE_SPI_LE)
    );

    typedef struct {
        int           ch;
        logic [W-1:0] data;
        logic [15:0]  done;
    } exp_t;

    exp_t        sb[$];
    int          fall_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] model_done = '0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expired(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: rebuilds each transfer from the pins while cmdReady is low.
    logic         in_xfer = 1'b0;
    int           busy_cyc, err_cyc, le_cyc, rises, busy_bad;
    logic [W-1:0] word;
    logic [C-1:0] act_mask;
    logic [C-1:0] prev_clk = '0;

    always @(negedge sysClk) begin
        cyc++;
        if (sysReset) begin
            if (in_xfer) chk("abort_le", le_cyc, 0);
            in_xfer  = 1'b0;
            sb.delete();
            prev_clk = '0;
        end else begin
            if (busy !== ~cmdReady) busy_bad++;
            if (!cmdReady) begin
                if (!in_xfer) begin
                    in_xfer  = 1'b1;
                    busy_cyc = 0;
                    err_cyc  = 0;
                    le_cyc   = 0;
                    rises    = 0;
                    busy_bad = 0;
                    word     = '0;
                    act_mask = '0;
                    fall_q.push_back(cyc);
                end
                busy_cyc++;
                if (errorStrobe) err_cyc++;
                if (|AFE_SPI_LE) le_cyc++;
                act_mask |= AFE_SPI_CLK | AFE_SPI_SDI | AFE_SPI_LE;
                for (int i = 0; i < C; i++) begin
                    if (AFE_SPI_CLK[i] && !prev_clk[i]) begin
                        rises++;
                        word = {word[W-2:0], AFE_SPI_SDI[i]};
                    end
                end
            end else if (in_xfer) begin
                in_xfer = 1'b0;
                if (sb.size() == 0) begin
                    expired("sb_empty");
                end else begin
                    exp_t e;
                    bit   ok;
                    e  = sb.pop_front();
                    ok = (e.ch < C);
                    chk("busy_len", busy_cyc, BUSY);
                    chk("busy_inv", busy_bad, 0);
                    chk("err_pulse", err_cyc, ok ? 0 : 1);
                    chk("pin_mask", act_mask, ok ? (1 << e.ch) : 0);
                    chk("clk_rises", rises, ok ? W : 0);
                    chk("sdi_word", word, ok ? e.data : '0);
                    chk("le_len", le_cyc, ok ? H : 0);
                    chk("done_count", doneCount, e.done);
                    chk("idle_pins",
                        {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
                end
            end
            prev_clk = AFE_SPI_CLK;
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge sysClk);
        while (!cmdReady && t < LIM) begin
            @(negedge sysClk);
            t++;
        end
        if (t >= LIM) expired("ready_wait");
    endtask

    task automatic push_exp(int ch, logic [W-1:0] d);
        exp_t e;
        model_done = model_done + 16'd1;
        e.ch   = ch;
        e.data = d;
        e.done = model_done;
        sb.push_back(e);
    endtask

    task automatic send(int ch, logic [W-1:0] d);
        wait_ready();
        cmdValid   = 1'b1;
        cmdChannel = 2'(ch);
        cmdData    = d;
        push_exp(ch, d);
        @(posedge sysClk);
        #1 cmdValid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !cmdReady) && t < LIM) begin
            @(negedge sysClk);
            t++;
        end
        if (t >= LIM) expired("idle_wait");
        @(negedge sysClk);
    endtask

    initial begin
        int cnt;
        int t;
        logic prevb;

        repeat (3) @(negedge sysClk);
        sysReset = 1'b0;
        @(negedge sysClk);
        chk("rst_ready", cmdReady, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", errorStrobe, 0);
        chk("rst_done", doneCount, 0);
        chk("rst_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);

        send(0, 16'hA5C3);
        wait_idle();
        send(1, 16'h0001);
        wait_idle();

        // Second command is presented throughout the first's busy time.
        @(negedge sysClk);
        fall_q.delete();
        cmdValid   = 1'b1;
        cmdChannel = 2'd0;
        cmdData    = 16'h1111;
        push_exp(0, 16'h1111);
        @(posedge sysClk);
        #1;
        cmdChannel = 2'd1;
        cmdData    = 16'h2222;
        push_exp(1, 16'h2222);
        wait_ready();
        @(posedge sysClk);
        #1 cmdValid = 1'b0;
        wait_idle();
        chk("b2b_accepts", fall_q.size(), 2);
        if (fall_q.size() == 2)
            chk("b2b_gap", fall_q[1] - fall_q[0], BUSY + 1);
        chk("b2b_done", doneCount, model_done);

        send(3, 16'hFFFF);
        wait_idle();

        for (int k = 0; k < 8; k++) begin
            send($urandom_range(0, 3), W'($urandom));
            wait_idle();
        end

        send(2, W'($urandom));
        cnt   = 0;
        t     = 0;
        prevb = 1'b0;
        while (cnt < 5 && t < LIM) begin
            @(negedge sysClk);
            if (AFE_SPI_CLK[2] && !prevb) cnt++;
            prevb = AFE_SPI_CLK[2];
            t++;
        end
        if (t >= LIM) expired("fifth_edge");
        @(posedge sysClk);
        #2 sysReset = 1'b1;
        #1;
        chk("mid_rst_pins", {AFE_SPI_CLK, AFE_SPI_SDI, AFE_SPI_LE}, 0);
        chk("mid_rst_ready", cmdReady, 1);
        chk("mid_rst_done", doneCount, 0);
        model_done = '0;
        repeat (3) @(negedge sysClk);
        sysReset = 1'b0;
        send(1, 16'h5A3C);
        wait_idle();

        force dut.done_cnt = 16'hFFFF;
        @(negedge sysClk);
        release dut.done_cnt;
        @(negedge sysClk);
        chk("preload", doneCount, 16'hFFFF);
        model_done = 16'hFFFF;
        send(0, W'($urandom));
        wait_idle();
        chk("wrap", doneCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
